// File: rtl/cp0_except_pkg.sv
// CP0 register numbers, exception-type codes and Status/Cause field indices.
// Shared by cp0_except and cp0_timer.
package cp0_except_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;
   localparam logic [4:0] CP0_CONFIG  = 5'd16;

   localparam logic [31:0] EXC_NONE = 32'h0;
   localparam logic [31:0] EXC_INT  = 32'h1;
   localparam logic [31:0] EXC_SYS  = 32'h8;
   localparam logic [31:0] EXC_INV  = 32'ha;
   localparam logic [31:0] EXC_TRAP = 32'hd;
   localparam logic [31:0] EXC_OV   = 32'hc;
   localparam logic [31:0] EXC_ERET = 32'he;

   localparam int MEM_SYS  = 8;
   localparam int MEM_INV  = 9;
   localparam int MEM_TRAP = 10;
   localparam int MEM_OV   = 11;
   localparam int MEM_ERET = 12;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_IM_LO = 8;
   localparam int ST_IM_HI = 15;

   localparam int CA_BD = 31;
   localparam int CA_IV = 23;
   localparam int CA_WP = 22;
   localparam int CA_IP_HI = 15;
   localparam int CA_IP_HW = 10;
   localparam int CA_IP_LO = 8;
   localparam int CA_IPSW_HI = 9;
   localparam int CA_EXC_HI = 6;
   localparam int CA_EXC_LO = 2;

   function automatic logic [31:0] epc_of(
      input logic [31:0] addr,
      input logic        slot
   );
      return slot ? addr - 32'd4 : addr;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair with the sticky timer interrupt.
// Compare hit shows on timer_int_o in the same cycle, then holds until Compare is written.
module cp0_timer
   import cp0_except_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        int_q;
   logic        hit;
   logic        wr_count;
   logic        wr_compare;

   assign wr_count   = we_i && (waddr_i == CP0_COUNT);
   assign wr_compare = we_i && (waddr_i == CP0_COMPARE);
   assign hit        = (compare_q != 32'h0) && (count_q == compare_q);

   // Count free-runs unless written; Compare write clears the sticky flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
         int_q     <= 1'b0;
      end else begin
         count_q <= wr_count ? wdata_i : count_q + 32'd1;
         if (wr_compare) begin
            compare_q <= wdata_i;
            int_q     <= 1'b0;
         end else if (hit) begin
            int_q <= 1'b1;
         end
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = int_q | hit;

endmodule

// File: rtl/cp0_except.sv
// CP0 register file and MEM/WB exception arbiter.
// CP0_CONFIG_PRID_EN enables the read-only PRId and Config registers.
module cp0_except
   import cp0_except_pkg::*;
#(
   parameter logic [31:0] STATUS_RST = 32'h1000_0000,
   parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] data_o,
   input  logic [31:0] excepttype_mem_i,
   input  logic [31:0] inst_addr_i,
   input  logic        in_delayslot_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] cp0_epc_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic [31:0] status_q;
   logic [31:0] cause_q;
   logic [31:0] epc_q;
   logic [31:0] status_eff;
   logic [31:0] cause_eff;
   logic [31:0] epc_eff;
   logic [31:0] exc_type;
   logic        int_pend;
   logic        commit;
   logic        eret;
   logic        byp_rd;
   logic [4:0]  exc_code;
   logic        unused_mem_bits;

   assign unused_mem_bits = &{1'b0, excepttype_mem_i[31:13],
                              excepttype_mem_i[7:0]};

   cp0_timer u_timer (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .count_o     (count_o),
      .compare_o   (compare_o),
      .timer_int_o (timer_int_o)
   );

   assign status_eff = (we_i && waddr_i == CP0_STATUS) ? wdata_i : status_q;
   assign cause_eff  = (we_i && waddr_i == CP0_CAUSE)  ? wdata_i : cause_q;
   assign epc_eff    = (we_i && waddr_i == CP0_EPC)    ? wdata_i : epc_q;

   // Priority arbitration; bubbles never raise anything.
   always_comb begin
      exc_type = EXC_NONE;
      int_pend = (|(cause_eff[CA_IP_HI:CA_IP_LO] &
                    status_eff[ST_IM_HI:ST_IM_LO])) &&
                 !status_eff[ST_EXL] && status_eff[ST_IE];
      if (inst_addr_i != 32'h0) begin
         if (int_pend)
            exc_type = EXC_INT;
         else if (excepttype_mem_i[MEM_SYS])
            exc_type = EXC_SYS;
         else if (excepttype_mem_i[MEM_INV])
            exc_type = EXC_INV;
         else if (excepttype_mem_i[MEM_TRAP])
            exc_type = EXC_TRAP;
         else if (excepttype_mem_i[MEM_OV])
            exc_type = EXC_OV;
         else if (excepttype_mem_i[MEM_ERET])
            exc_type = EXC_ERET;
      end
   end

   assign commit   = (exc_type != EXC_NONE) && (exc_type != EXC_ERET);
   assign eret     = (exc_type == EXC_ERET);
   assign exc_code = (exc_type == EXC_INT) ? 5'd0 : exc_type[4:0];

   // MTC0 first, exception/eret updates afterwards so they win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= STATUS_RST;
         cause_q  <= 32'h0;
         epc_q    <= 32'h0;
      end else begin
         cause_q[CA_IP_HI:CA_IP_HW] <= int_i;
         if (we_i) begin
            case (waddr_i)
               CP0_STATUS: status_q <= wdata_i;
               CP0_EPC:    epc_q    <= wdata_i;
               CP0_CAUSE: begin
                  cause_q[CA_IPSW_HI:CA_IP_LO] <= wdata_i[CA_IPSW_HI:CA_IP_LO];
                  cause_q[CA_IV] <= wdata_i[CA_IV];
                  cause_q[CA_WP] <= wdata_i[CA_WP];
               end
               default: ;
            endcase
         end
         if (commit) begin
            if (!status_eff[ST_EXL]) begin
               epc_q <= epc_of(inst_addr_i, in_delayslot_i);
               cause_q[CA_BD] <= in_delayslot_i;
            end
            cause_q[CA_EXC_HI:CA_EXC_LO] <= exc_code;
            status_q[ST_EXL] <= 1'b1;
         end else if (eret) begin
            status_q[ST_EXL] <= 1'b0;
         end
      end
   end

   assign byp_rd = we_i && (waddr_i == raddr_i);

   // MFC0 read mux with same-cycle write bypass.
   always_comb begin
      data_o = 32'h0;
      case (raddr_i)
         CP0_COUNT:   data_o = byp_rd ? wdata_i : count_o;
         CP0_COMPARE: data_o = byp_rd ? wdata_i : compare_o;
         CP0_STATUS:  data_o = status_eff;
         CP0_CAUSE:   data_o = cause_eff;
         CP0_EPC:     data_o = epc_eff;
`ifdef CP0_CONFIG_PRID_EN
         CP0_PRID:    data_o = PRID_VAL;
         CP0_CONFIG:  data_o = CONFIG_VAL;
`else
         CP0_PRID:    data_o = 32'h0;
         CP0_CONFIG:  data_o = 32'h0;
`endif
         default:     data_o = 32'h0;
      endcase
   end

   assign excepttype_o = exc_type;
   assign cp0_epc_o    = epc_eff;
   assign status_o     = status_q;
   assign cause_o      = cause_q;

endmodule

// File: tb/tb_cp0_except.sv
// Directed bench for cp0_except: arbitration table plus
// timer, commit, eret, bypass and reset sequences.
module tb_cp0_except;

   logic        clk;
   logic        rst;
   logic [5:0]  int_i;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [31:0] excepttype_mem_i;
   logic [31:0] inst_addr_i;
   logic        in_delayslot_i;
   logic [31:0] excepttype_o;
   logic [31:0] cp0_epc_o;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] count_o;
   logic [31:0] compare_o;
   logic        timer_int_o;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] exc;
      logic [31:0] addr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[12];

   cp0_except dut (
      .clk              (clk),
      .rst              (rst),
      .int_i            (int_i),
      .we_i             (we_i),
      .waddr_i          (waddr_i),
      .wdata_i          (wdata_i),
      .raddr_i          (raddr_i),
      .data_o           (data_o),
      .excepttype_mem_i (excepttype_mem_i),
      .inst_addr_i      (inst_addr_i),
      .in_delayslot_i   (in_delayslot_i),
      .excepttype_o     (excepttype_o),
      .cp0_epc_o        (cp0_epc_o),
      .status_o         (status_o),
      .cause_o          (cause_o),
      .count_o          (count_o),
      .compare_o        (compare_o),
      .timer_int_o      (timer_int_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: act=%h req=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1;
      waddr_i = a;
      wdata_i = d;
      step();
      we_i = 1'b0;
   endtask

   task automatic mem(input logic [31:0] e, input logic [31:0] a,
                      input logic s);
      excepttype_mem_i = e;
      inst_addr_i = a;
      in_delayslot_i = s;
      #1;
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      int_i = '0;
      we_i = 1'b0;
      waddr_i = '0;
      wdata_i = '0;
      raddr_i = '0;
      excepttype_mem_i = '0;
      inst_addr_i = '0;
      in_delayslot_i = 1'b0;

      tbl[0]  = '{32'h0000_0100, 32'h10, 32'h8, "sys"};
      tbl[1]  = '{32'h0000_0200, 32'h10, 32'ha, "inv"};
      tbl[2]  = '{32'h0000_0400, 32'h10, 32'hd, "trap"};
      tbl[3]  = '{32'h0000_0800, 32'h10, 32'hc, "ov"};
      tbl[4]  = '{32'h0000_1000, 32'h10, 32'he, "eret"};
      tbl[5]  = '{32'h0000_0900, 32'h10, 32'h8, "sys_ov"};
      tbl[6]  = '{32'h0000_0600, 32'h10, 32'ha, "inv_trap"};
      tbl[7]  = '{32'h0000_1c00, 32'h10, 32'hd, "trap_ov_eret"};
      tbl[8]  = '{32'h0000_1800, 32'h10, 32'hc, "ov_eret"};
      tbl[9]  = '{32'h0000_0100, 32'h00, 32'h0, "bubble_sys"};
      tbl[10] = '{32'h0000_0000, 32'h10, 32'h0, "none"};
      tbl[11] = '{32'h0000_00ff, 32'h10, 32'h0, "low_bits"};

      repeat (2) @(negedge clk);
      chk("rst_status", status_o, 32'h1000_0000);
      chk("rst_cause", cause_o, 32'h0);
      chk("rst_epc", cp0_epc_o, 32'h0);
      chk("rst_count", count_o, 32'h0);
      chk("rst_timer", {31'h0, timer_int_o}, 32'h0);
      chk("rst_exc", excepttype_o, 32'h0);
      rst = 1'b1;
      step();
      step();
      step();
      chk("count_inc3", count_o, 32'd3);

      for (int i = 0; i < 12; i++) begin
         mem(tbl[i].exc, tbl[i].addr, 1'b0);
         chk(tbl[i].name, excepttype_o, tbl[i].exp);
         mem(32'h0, 32'h0, 1'b0);
      end

      mtc0(CP0_COUNT_N, 32'h0);
      chk("count_wr", count_o, 32'h0);
      mtc0(CP0_COMPARE_N, 32'd5);
      chk("compare_wr", compare_o, 32'd5);
      n = 0;
      while (count_o != 32'd5 && n < 20) begin
         step();
         n++;
      end
      chk("count_reach5", count_o, 32'd5);
      chk("timer_set", {31'h0, timer_int_o}, 32'h1);
      step();
      step();
      chk("timer_sticky", {31'h0, timer_int_o}, 32'h1);
      mtc0(CP0_COMPARE_N, 32'd9);
      chk("timer_clr", {31'h0, timer_int_o}, 32'h0);

      mem(32'h100, 32'h100, 1'b0);
      chk("sys_type", excepttype_o, 32'h8);
      step();
      mem(32'h0, 32'h0, 1'b0);
      chk("sys_epc", cp0_epc_o, 32'h100);
      chk("sys_status", status_o, 32'h1000_0002);
      chk("sys_code", {27'h0, cause_o[6:2]}, 32'h8);

      mem(32'h1000, 32'h104, 1'b0);
      chk("eret1_type", excepttype_o, 32'he);
      step();
      mem(32'h0, 32'h0, 1'b0);
      chk("eret1_status", status_o, 32'h1000_0000);
      chk("eret1_epc", cp0_epc_o, 32'h100);

      mem(32'h800, 32'h204, 1'b1);
      chk("ov_type", excepttype_o, 32'hc);
      step();
      mem(32'h0, 32'h0, 1'b0);
      chk("ov_epc", cp0_epc_o, 32'h200);
      chk("ov_bd", {31'h0, cause_o[31]}, 32'h1);
      chk("ov_code", {27'h0, cause_o[6:2]}, 32'hc);

      mem(32'h100, 32'h400, 1'b0);
      chk("exl_sys_type", excepttype_o, 32'h8);
      step();
      mem(32'h0, 32'h0, 1'b0);
      chk("exl_epc_kept", cp0_epc_o, 32'h200);
      chk("exl_bd_kept", {31'h0, cause_o[31]}, 32'h1);
      chk("exl_code", {27'h0, cause_o[6:2]}, 32'h8);
      mem(32'h1000, 32'h404, 1'b0);
      step();
      mem(32'h0, 32'h0, 1'b0);

      mtc0(CP0_STATUS_N, 32'h0000_0401);
      int_i = 6'b000001;
      step();
      mem(32'h0, 32'h500, 1'b0);
      chk("int_type", excepttype_o, 32'h1);
      mem(32'h0, 32'h0, 1'b0);
      chk("int_bubble", excepttype_o, 32'h0);
      mem(32'h100, 32'h500, 1'b0);
      chk("int_over_sys", excepttype_o, 32'h1);
      step();
      mem(32'h0, 32'h504, 1'b0);
      chk("int_status", status_o, 32'h0000_0403);
      chk("int_code", {27'h0, cause_o[6:2]}, 32'h0);
      chk("int_epc", cp0_epc_o, 32'h500);
      chk("int_masked", excepttype_o, 32'h0);
      mem(32'h1000, 32'h508, 1'b0);
      chk("eret2_type", excepttype_o, 32'he);
      step();
      mem(32'h0, 32'h50c, 1'b0);
      chk("int_recur", excepttype_o, 32'h1);
      mem(32'h0, 32'h0, 1'b0);
      int_i = 6'b0;
      step();

      we_i = 1'b1;
      waddr_i = CP0_EPC_N;
      wdata_i = 32'h300;
      mem(32'h1000, 32'h600, 1'b0);
      chk("byp_epc", cp0_epc_o, 32'h300);
      chk("byp_eret", excepttype_o, 32'he);
      step();
      we_i = 1'b0;
      mem(32'h0, 32'h0, 1'b0);
      chk("epc_wr", cp0_epc_o, 32'h300);
      chk("eret3_status", status_o, 32'h0000_0401);

      we_i = 1'b1;
      waddr_i = CP0_EPC_N;
      wdata_i = 32'h777;
      mem(32'h100, 32'h700, 1'b0);
      step();
      we_i = 1'b0;
      mem(32'h0, 32'h0, 1'b0);
      chk("exc_wins_epc", cp0_epc_o, 32'h700);

      mtc0(CP0_CAUSE_N, 32'hffff_ffff);
      chk("cause_mask", cause_o, 32'h00c0_0320);

      raddr_i = CP0_STATUS_N;
      #1;
      chk("rd_status", data_o, 32'h0000_0403);
      raddr_i = CP0_CAUSE_N;
      #1;
      chk("rd_cause", data_o, 32'h00c0_0320);
      raddr_i = 5'd15;
      #1;
`ifdef CP0_CONFIG_PRID_EN
      chk("rd_prid", data_o, 32'h0048_0102);
`else
      chk("rd_prid", data_o, 32'h0);
`endif
      raddr_i = 5'd3;
      #1;
      chk("rd_unlisted", data_o, 32'h0);
      we_i = 1'b1;
      waddr_i = CP0_COMPARE_N;
      wdata_i = 32'h1234;
      raddr_i = CP0_COMPARE_N;
      #1;
      chk("rd_bypass", data_o, 32'h1234);
      we_i = 1'b0;

      #2;
      rst = 1'b0;
      #1;
      chk("arst_status", status_o, 32'h1000_0000);
      chk("arst_epc", cp0_epc_o, 32'h0);
      chk("arst_cause", cause_o, 32'h0);
      chk("arst_count", count_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   localparam logic [4:0] CP0_COUNT_N   = 5'd9;
   localparam logic [4:0] CP0_COMPARE_N = 5'd11;
   localparam logic [4:0] CP0_STATUS_N  = 5'd12;
   localparam logic [4:0] CP0_CAUSE_N   = 5'd13;
   localparam logic [4:0] CP0_EPC_N     = 5'd14;

endmodule
